// File: rtl/dmem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants for the data-memory bus unit: bus SIZE
//               codes, RISC-V load/store funct3 encodings, FSM state codes,
//               and small helpers for size decode and alignment checks.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Bus SIZE codes
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    // RISC-V funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // funct3[1:0] selects access width; the unused code 11 falls back to word.
    function automatic logic [1:0] f3_to_size(input logic [2:0] f3);
        logic [1:0] size;
        case (f3[1:0])
            2'b00:   size = SIZE_BYTE;
            2'b01:   size = SIZE_HALF;
            default: size = SIZE_WORD;
        endcase
        return size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        return ((size == SIZE_HALF) && addr_lo[0]) ||
               ((size == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_load_extend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_load_extend
// Description : Combinational load-data formatter. Takes the right-justified
//               word captured from the bus and sign- or zero-extends the byte
//               or halfword according to the access size.
// Ports       : data_i  - captured bus data
//               size_i  - bus SIZE code of the access
//               sign_i  - 1 = sign-extend (LB/LH), 0 = zero-extend
//               data_o  - extended result
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_load_extend
    import dmem_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic [BIT_WIDTH-1:0] data_i,
    input  logic [1:0]           size_i,
    input  logic                 sign_i,
    output logic [BIT_WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (size_i)
            SIZE_BYTE: data_o = {{(BIT_WIDTH-8){sign_i & data_i[7]}},  data_i[7:0]};
            SIZE_HALF: data_o = {{(BIT_WIDTH-16){sign_i & data_i[15]}}, data_i[15:0]};
            default:   data_o = data_i;
        endcase
    end

endmodule : dmem_load_extend
`default_nettype wire

// File: rtl/dmem_bus_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_bus_unit
// Description : Load/store bus master between the MEM pipeline stage and the
//               external data-memory bus. Accepts one request at a time,
//               drives MREQ/WRITE/SIZE/DAD/DDT until ACKD_n is sampled low or
//               the wait counter expires, then pulses resp_valid for one cycle.
//               A request presented during the response cycle is accepted
//               back-to-back.
// Ports       : clk, rst (async, active low)
//               req_*   - pipeline request (valid/write/funct3/addr/wdata)
//               req_ready, stall, resp_valid/resp_rdata/resp_err - pipeline side
//               DAD, DDT (bidirectional), MREQ, WRITE, SIZE, ACKD_n - bus side
// Options     : DMEM_MISALIGN_TRAP_EN - when defined, misaligned halfword/word
//               requests never reach the bus and complete with resp_err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus_unit
    import dmem_pkg::*;
#(
    parameter int BIT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [BIT_WIDTH-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 stall,
    output logic [BIT_WIDTH-1:0] DAD,
    inout  wire  [BIT_WIDTH-1:0] DDT,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    input  logic                 ACKD_n
);

    // Counter value on the last BUS cycle before giving up.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [BIT_WIDTH-1:0] addr_q,  addr_d;
    logic [1:0]           size_q,  size_d;
    logic                 sign_q,  sign_d;
    logic                 write_q, write_d;
    logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
    logic [BIT_WIDTH-1:0] rdata_q, rdata_d;
    logic                 err_q,   err_d;
    logic [7:0]           cnt_q,   cnt_d;

    logic [1:0]           w_req_size;
    logic [BIT_WIDTH-1:0] w_ext;

    assign w_req_size = f3_to_size(req_funct3);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sign_d  = sign_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = w_req_size;
                    sign_d  = ~req_funct3[2];
                    write_d = req_write;
                    err_d   = 1'b0;
                    cnt_d   = 8'd0;
                    // Store data is right-justified and zero-padded above the access width.
                    case (w_req_size)
                        SIZE_BYTE: wdata_d = {{(BIT_WIDTH-8){1'b0}},  req_wdata[7:0]};
                        SIZE_HALF: wdata_d = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
                        default:   wdata_d = req_wdata;
                    endcase
                    state_d = ST_BUS;
`ifdef DMEM_MISALIGN_TRAP_EN
                    // Misaligned accesses skip the bus entirely and report an error.
                    if (is_misaligned(w_req_size, req_addr[1:0])) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                // An acknowledge on the final wait cycle still wins over the timeout.
                if (!ACKD_n) begin
                    rdata_d = write_q ? '0 : DDT;
                    state_d = ST_RESP;
                end else if (cnt_q >= TO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= SIZE_WORD;
            sign_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    dmem_load_extend #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_load_extend (
        .data_i (rdata_q),
        .size_i (size_q),
        .sign_i (sign_q),
        .data_o (w_ext)
    );

    assign MREQ       = (state_q == ST_BUS);
    assign WRITE      = (state_q == ST_BUS) && write_q;
    assign DAD        = addr_q;
    assign SIZE       = size_q;
    assign DDT        = WRITE ? wdata_q : {BIT_WIDTH{1'bz}};

    assign req_ready  = (state_q != ST_BUS);
    assign stall      = (state_q == ST_BUS);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = (state_q == ST_RESP) && err_q;
    assign resp_rdata = ((state_q == ST_RESP) && !err_q) ? w_ext : '0;

endmodule : dmem_bus_unit
`default_nettype wire

// File: doc/dmem_bus_unit.md
Name: dmem_bus_unit

Overview:
- Load/store bus master between the core's MEM pipeline stage and the external data-memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Accepts one load or store per transaction from the pipeline and drives the bus handshake.
- Formats sub-word store data and sign/zero-extends load data.
- Stalls the pipeline until the bus acknowledges.

Parameters:
- BIT_WIDTH, 32, data and address width.
- TIMEOUT_CYCLES, 255, cycles without ACKD_n before a bus error (8-bit counter).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM stage has a load/store.
- req_write  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- req_addr  in  32  effective address.
- req_wdata  in  32  store data, rs2 value, right-justified.
- req_ready  out  1  unit can accept a request this cycle.
- resp_valid  out  1  one-cycle pulse: transaction complete.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  with resp_valid: bus timeout or misalign.
- stall  out  1  high while a transaction is in flight.
- DAD  out  32  bus address.
- DDT  inout  32  bus data; driven only when WRITE=1, else high-Z.
- MREQ  out  1  bus request.
- WRITE  out  1  1=write cycle.
- SIZE  out  2  00 word, 01 half, 10 byte.
- ACKD_n  in  1  active-low acknowledge.

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE.
  - MREQ=0, WRITE=0, SIZE=00, DAD=0.
  - DDT high-Z.
  - req_ready=1, stall=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - Timeout counter cleared.
  - Reset during BUS abandons the transaction with no response.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch address, size, sign flag and write data; go to BUS.
  - BUS: MREQ=1, DAD/WRITE/SIZE held stable, req_ready=0, stall=1. ACKD_n is sampled at each rising edge.
    - ACKD_n=0: capture DDT for loads, pulse resp_valid next cycle, go to RESP.
    - Counter reaches TIMEOUT_CYCLES: go to RESP with resp_err=1 and resp_rdata=0.
  - RESP: MREQ=0, resp_valid=1 for one cycle, req_ready=1.
    - A new req_valid in RESP is accepted (back-to-back): go to BUS next edge.
    - Otherwise go to IDLE.
- ACKD_n is ignored outside BUS, so a stale low level from the previous transaction has no effect.
- Minimum latency: accept edge N, ack sampled at N+1, resp_valid during cycle N+1..N+2. One ack wait cycle gives 2-cycle occupancy.
- SIZE mapping: funct3[1:0] 10→00, 01→01, 00→10.
- Store data: right-justified on DDT.
  - Byte: DDT={24'b0, wdata[7:0]}.
  - Half: {16'b0, wdata[15:0]}.
  - Word: as-is.
- Load data arrives right-justified.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- Address on DAD is req_addr unmodified. The bus handles byte-lane placement.
- The timeout counter resets on entry to BUS and saturates.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠00, never asserts MREQ.
  - The unit goes IDLE→RESP directly, with resp_err=1, resp_rdata=0.
  - Store data is not driven.
- Undefined: misaligned requests are issued on the bus unchanged. resp_err reflects only timeout.

Decomposition:
- Shared package dmem_pkg:
  - Constants SIZE_WORD=2'b00, SIZE_HALF=2'b01, SIZE_BYTE=2'b10.
  - funct3 load/store encodings.
  - State encoding IDLE/BUS/RESP.
- One natural sub-module: dmem_load_extend, a combinational size/sign extender from captured DDT to resp_rdata. The FSM stays in the top module.

Test Plan:
- LW at 0x0800_0010 with ACKD_n low on the first BUS edge, memory word 0xDEADBEEF:
  - MREQ=1, WRITE=0, SIZE=00 for exactly one cycle.
  - resp_rdata=0xDEADBEEF, resp_valid pulses once, stall high for 1 cycle.
- LB and LBU at 0x0800_0003 with DDT=0x00000080:
  - LB: resp_rdata=0xFFFFFF80, SIZE=10.
  - LBU: resp_rdata=0x00000080.
- SB of wdata 0x12345641 to 0xF000_0000:
  - DDT=0x00000041, WRITE=1, SIZE=10 during BUS.
  - DDT high-Z in the following cycle.
- Back-to-back SW 0xCAFEF00D then LH to 0x0800_0006, req_valid held through RESP:
  - Second MREQ asserted the cycle after the first resp_valid.
  - No lost or duplicated transactions.
- ACKD_n held high:
  - After 255 BUS cycles, resp_valid=1, resp_err=1, resp_rdata=0, then IDLE.
  - Repeat with rst pulsed low mid-BUS: MREQ=0 immediately, no resp_valid.
- DMEM_MISALIGN_TRAP_EN defined, LW at 0x0800_0002:
  - MREQ never asserted, resp_err=1 one cycle after accept.
  - Without the macro, MREQ is asserted with DAD=0x0800_0002.
